// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU result path
// (requester A) and the load return path (requester B). One write is accepted
// per cycle; contention is resolved round-robin and the winning write is
// registered onto rw/writereg/data one cycle after acceptance.
//
// Build option: define WB_ARB_FIXED_PRIO_EN to give A strict priority over B.
// A then wins every tie and no grant history is stored. The default build,
// with the macro undefined, is round-robin.
module regfile_wb_arbiter #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [N-1:0]  a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [N-1:0]  b_data,
    output logic          b_ready,
    input  logic          stall,
    output logic          rw,
    output logic [AW-1:0] writereg,
    output logic [N-1:0]  data,
    output logic [15:0]   conflict_cnt
);

    logic          grant_a;
    logic          grant_b;
    logic          xfer_a;
    logic          xfer_b;
    logic          both_valid;

    logic          rw_reg;
    logic [AW-1:0] writereg_reg;
    logic [N-1:0]  data_reg;
    logic [15:0]   conflict_cnt_reg;

    assign both_valid = a_valid & b_valid;

`ifdef WB_ARB_FIXED_PRIO_EN
    // Strict priority: A wins whenever it has a write, so B may wait indefinitely.
    always_comb begin
        grant_a = a_valid;
        grant_b = b_valid & ~a_valid;
    end
`else
    // A 1 in this bit means B took the most recent transfer.
    // Reset leaves it pointing at B, so A wins the first tie.
    logic last_grant_b_reg;

    // Round-robin: on a tie, grant the side that did not win last time.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (both_valid) begin
            grant_a = last_grant_b_reg;
            grant_b = ~last_grant_b_reg;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    // Remember which side last transferred. Stall and idle cycles leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_b_reg <= 1'b1;
        end else if (xfer_a) begin
            last_grant_b_reg <= 1'b0;
        end else if (xfer_b) begin
            last_grant_b_reg <= 1'b1;
        end
    end
`endif

    // Ready is held low during reset, so nothing is accepted in a reset cycle.
    assign a_ready = grant_a & ~stall & ~rst;
    assign b_ready = grant_b & ~stall & ~rst;
    assign xfer_a  = a_valid & a_ready;
    assign xfer_b  = b_valid & b_ready;

    // Register the accepted write. Register x0 is hardwired to zero, so its
    // writes update writereg/data but never raise rw.
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_reg       <= 1'b0;
            writereg_reg <= '0;
            data_reg     <= '0;
        end else if (xfer_a) begin
            rw_reg       <= (a_addr != '0);
            writereg_reg <= a_addr;
            data_reg     <= a_data;
        end else if (xfer_b) begin
            rw_reg       <= (b_addr != '0);
            writereg_reg <= b_addr;
            data_reg     <= b_data;
        end else begin
            rw_reg       <= 1'b0;
        end
    end

    // Count cycles in which both sides want the port and it is writable.
    // The count saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_reg <= '0;
        end else if (both_valid && !stall && conflict_cnt_reg != 16'hFFFF) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign rw           = rw_reg;
    assign writereg     = writereg_reg;
    assign data         = data_reg;
    assign conflict_cnt = conflict_cnt_reg;

endmodule
